gpio_in_conditioner: RTL and testbench
======================================

// Module: gpio_in_conditioner
// PURPOSE
//  Receive-side counterpart to the team top-level GPIO output drive.
//  Conditions raw breakout-board inputs (gpio_in) before project logic uses them:
//  - per-pin N-stage synchronizer
//  - per-pin debounce counter
//  - one-cycle rise/fall pulses
//  - sticky event-flag register with an acknowledge handshake
//  Sits between the team wrapper's gpio_in and the project core.
// PARAMETERS
//  WIDTH            34  number of GPIO input pins conditioned
//  SYNC_STAGES      2   synchronizer flops per pin (>=2)
//  DEBOUNCE_CYCLES  16  consecutive stable cycles required to accept a new level (>=1)
// PORTS
//  clk        in   1      system clock
//  nrst       in   1      synchronous active-low reset
//  en         in   1      block enable; low = freeze conditioned state
//  gpio_in    in   WIDTH  raw asynchronous pin levels
//  clean_out  out  WIDTH  debounced, synchronized pin levels
//  rise_pulse out  WIDTH  1-cycle pulse when clean_out bit goes 0->1
//  fall_pulse out  WIDTH  1-cycle pulse when clean_out bit goes 1->0
//  evt_flags  out  WIDTH  sticky per-pin "edge seen" flags
//  evt_valid  out  1      |evt_flags
//  evt_ack    in   1      clears evt_flags (handshake with consumer)
// BEHAVIOUR
//  Clock and reset:
//  - Single clock domain (clk). Reset sampled on posedge clk only: nrst=0 at an edge
//    zeroes sync chains, counters, clean_out, pulses and evt_flags.
//  - All outputs reset to 0. Reset mid-debounce discards the partial count.
//  Synchronizer:
//  - sync[0] <= gpio_in; sync[i] <= sync[i-1]; s = sync[SYNC_STAGES-1].
//  - Runs whenever nrst=1, regardless of en.
//  Debounce, per pin, counter width CW = $clog2(DEBOUNCE_CYCLES+1):
//  - en=0: cnt <= 0; clean_out holds; rise/fall = 0.
//  - s == clean_out: cnt <= 0 (glitch shorter than threshold is discarded).
//  - s != clean_out and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//  - s != clean_out and cnt == DEBOUNCE_CYCLES-1: clean_out <= s; cnt <= 0;
//    rise_pulse or fall_pulse is 1 in the same cycle clean_out changes.
//  - Latency: a stable input change is reflected on clean_out after exactly
//    SYNC_STAGES+DEBOUNCE_CYCLES rising edges; edge 1 is the edge that first captures it.
//  - Counter never wraps; max value is DEBOUNCE_CYCLES-1.
//  - Pulses are registered: high exactly one cycle, never both for one pin.
//  Event flags:
//  - evt_ack=0: evt_flags <= evt_flags | rise_pulse_next | fall_pulse_next
//    (set in the same cycle the pulse appears).
//  - evt_ack=1: evt_flags <= rise_pulse_next | fall_pulse_next. Simultaneous new
//    edge and ack: the new edge survives; all older flags clear.
//  - evt_ack while evt_valid=0: harmless.
//  - en=0 does not clear evt_flags; no new flags set while en=0.
//  - evt_valid is combinational from evt_flags.
// TESTING
//  - Reset: nrst=0 for 2 cycles with gpio_in='1 -> all outputs 0; release ->
//    clean_out='1 at edge 18 after release (S=2, D=16); rise_pulse='1 for one cycle.
//  - Glitch reject: pin3 0->1 for 15 cycles then back to 0 ->
//    clean_out[3], rise_pulse[3] and evt_flags[3] stay 0.
//  - Latency: pin0 0->1 held -> clean_out[0]=1 after exactly 18 edges; rise_pulse[0]
//    high 1 cycle; evt_flags[0]=1, evt_valid=1.
//    Then 1->0 -> fall_pulse[0] after 18 edges.
//  - Handshake race: evt_flags[0]=1; assert evt_ack in the same cycle pin5's fall pulse
//    fires -> evt_flags = 34'h20, evt_valid stays 1; next ack -> 0.
//  - Enable: drop en at debounce count 10, hold 20 cycles with pin toggled ->
//    clean_out frozen, no pulses; re-assert en -> full 16-cycle count restarts.
//  - Reset mid-debounce: pin counting at 12, pulse nrst low 1 cycle ->
//    count lost; clean_out 0; settles 18 edges after release.

Source files
------------

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: per-pin synchronizer, debounce, edge pulses and sticky event flags
module gpio_in_conditioner #(
    parameter int WIDTH           = 34,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] evt_flags,
    output logic             evt_valid,
    input  logic             evt_ack
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] s, chg, hit;
    logic [WIDTH-1:0] clean_q, clean_d, rise_q, rise_d, fall_q, fall_d, evt_q, evt_d;

    assign s = sync_q[SYNC_STAGES-1];

    // A pin only counts while enabled and differing; the count is discarded otherwise
    always_comb begin
        chg = '0;
        hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            chg[i]   = en && (s[i] != clean_q[i]);
            hit[i]   = chg[i] && (cnt_q[i] == CNT_MAX);
            cnt_d[i] = (chg[i] && cnt_q[i] != CNT_MAX) ? cnt_q[i] + CW'(1) : '0;
        end
    end

    assign clean_d = (clean_q & ~hit) | (s & hit);
    assign rise_d  = hit & s;
    assign fall_d  = hit & ~s;
    assign evt_d   = (evt_ack ? '0 : evt_q) | hit;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            evt_q   <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign evt_flags  = evt_q;
    assign evt_valid  = |evt_q;
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner: table-driven vectors checked through a cycle-stamped scoreboard
module tb_gpio_in_conditioner;
    localparam int W = 34;

    logic         clk = 0;
    logic         nrst, en, evt_ack, evt_valid;
    logic [W-1:0] gpio_in, clean_out, rise_pulse, fall_pulse, evt_flags;

    gpio_in_conditioner dut (
        .clk(clk), .nrst(nrst), .en(en), .gpio_in(gpio_in),
        .clean_out(clean_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .evt_flags(evt_flags), .evt_valid(evt_valid), .evt_ack(evt_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        nm;
        int           at;
        logic [W-1:0] c, r, f, e;
    } sb_t;

    typedef struct {
        string        nm;
        logic [W-1:0] g;
        logic         en_v, ack_v;
        int           n;
        logic [W-1:0] c, r, f, e;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_t x;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            x = sb.pop_front();
            if (x.at < cyc) begin
                nvec++;
                nfail++;
                $display("FAIL %s: missed check slot %0d (now %0d)", x.nm, x.at, cyc);
            end else begin
                chk({x.nm, " clean"}, clean_out, x.c);
                chk({x.nm, " rise"}, rise_pulse, x.r);
                chk({x.nm, " fall"}, fall_pulse, x.f);
                chk({x.nm, " flags"}, evt_flags, x.e);
                chk({x.nm, " valid"}, {{(W-1){1'b0}}, evt_valid}, {{(W-1){1'b0}}, |x.e});
            end
        end
    end

    task automatic expect_at(int k, string nm, logic [W-1:0] c, r, f, e);
        sb_t x;
        int  idx;
        x.nm = nm; x.at = cyc + k; x.c = c; x.r = r; x.f = f; x.e = e;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].at > x.at) idx--;
        sb.insert(idx, x);
    endtask

    task automatic run(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(string nm, logic [W-1:0] g, logic en_v, logic ack_v, int n,
                       logic [W-1:0] c, logic [W-1:0] r, logic [W-1:0] f, logic [W-1:0] e);
        vec_t v;
        v.nm = nm; v.g = g; v.en_v = en_v; v.ack_v = ack_v; v.n = n;
        v.c = c; v.r = r; v.f = f; v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        logic [W-1:0] ones = '1;
        add("ack_after_rst", ones,  1, 1, 1,  ones, 0, 0, 0);
        add("fall_all_pre",  0,     1, 0, 17, ones, 0, 0, 0);
        add("fall_all",      0,     1, 0, 1,  0, 0, ones, ones);
        add("fall_all_end",  0,     1, 0, 1,  0, 0, 0, ones);
        add("ack_clear",     0,     1, 1, 1,  0, 0, 0, 0);
        add("ack_idle",      0,     1, 1, 1,  0, 0, 0, 0);
        add("glitch_hi15",   34'h8, 1, 0, 15, 0, 0, 0, 0);
        add("glitch_back",   0,     1, 0, 10, 0, 0, 0, 0);
        add("p0_rise_pre",   34'h1, 1, 0, 17, 0, 0, 0, 0);
        add("p0_rise",       34'h1, 1, 0, 1,  34'h1, 34'h1, 0, 34'h1);
        add("p0_rise_end",   34'h1, 1, 0, 1,  34'h1, 0, 0, 34'h1);
        add("p0_fall_pre",   0,     1, 0, 17, 34'h1, 0, 0, 34'h1);
        add("p0_fall",       0,     1, 0, 1,  0, 0, 34'h1, 34'h1);
        add("p0_fall_end",   0,     1, 0, 1,  0, 0, 0, 34'h1);
        add("p0_ack",        0,     1, 1, 1,  0, 0, 0, 0);
        add("p5_rise",       34'h20, 1, 0, 18, 34'h20, 34'h20, 0, 34'h20);
        add("p5_ack",        34'h20, 1, 1, 1,  34'h20, 0, 0, 0);
        add("p0_rise2",      34'h21, 1, 0, 18, 34'h21, 34'h1, 0, 34'h1);
        add("race_pre",      34'h01, 1, 0, 17, 34'h21, 0, 0, 34'h1);
        add("race_ack",      34'h01, 1, 1, 1,  34'h01, 0, 34'h20, 34'h20);
        add("race_ack2",     34'h01, 1, 1, 1,  34'h01, 0, 0, 0);
        add("en_cnt10",      34'h81, 1, 0, 12, 34'h01, 0, 0, 0);
        add("en_off_a",      34'h01, 0, 0, 5,  34'h01, 0, 0, 0);
        add("en_off_b",      34'h81, 0, 0, 5,  34'h01, 0, 0, 0);
        add("en_off_c",      34'h01, 0, 0, 5,  34'h01, 0, 0, 0);
        add("en_off_d",      34'h81, 0, 0, 5,  34'h01, 0, 0, 0);
        add("en_on_pre",     34'h81, 1, 0, 15, 34'h01, 0, 0, 0);
        add("en_on_rise",    34'h81, 1, 0, 1,  34'h81, 34'h80, 0, 34'h80);
        add("en_on_ack",     34'h81, 1, 1, 1,  34'h81, 0, 0, 0);

        nrst = 0; en = 1; evt_ack = 0; gpio_in = '1;
        expect_at(2, "reset", 0, 0, 0, 0);
        run(2);
        nrst = 1;
        expect_at(17, "rst_rel_pre", 0, 0, 0, 0);
        expect_at(18, "rst_rel", ones, ones, 0, ones);
        expect_at(19, "rst_rel_end", ones, 0, 0, ones);
        run(19);

        foreach (tbl[i]) begin
            gpio_in = tbl[i].g; en = tbl[i].en_v; evt_ack = tbl[i].ack_v;
            expect_at(tbl[i].n, tbl[i].nm, tbl[i].c, tbl[i].r, tbl[i].f, tbl[i].e);
            run(tbl[i].n);
        end

        // pin 9 reaches count 12, then a one-cycle reset wipes the partial count
        evt_ack = 0; en = 1; gpio_in = 34'h281;
        expect_at(14, "mid_cnt12", 34'h81, 0, 0, 0);
        run(14);
        nrst = 0;
        expect_at(1, "mid_rst", 0, 0, 0, 0);
        run(1);
        nrst = 1;
        expect_at(17, "mid_pre", 0, 0, 0, 0);
        expect_at(18, "mid_settle", 34'h281, 34'h281, 0, 34'h281);
        run(19);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            nvec++;
            nfail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
